ifu_fetch: RTL and testbench

//  Instruction-fetch stage of the 5-stage core, directly downstream of the PC generator.

---
 rtl/ifu_fetch_pkg.sv | 23 ++
 rtl/ifu_fetch_if.sv | 34 +++
 rtl/ifu_out_buf.sv | 47 ++++
 rtl/ifu_fetch.sv | 124 ++++++++++++
 tb/tb_ifu_fetch.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this slice: IFU_PERF_CNT_EN.
package ifu_fetch_pkg;

    localparam int IFU_DATA_WIDTH = 32;
    localparam int IFU_INST_WIDTH = 32;

    // Substituted for the instruction word whenever the fetch faulted (addi x0, x0, 0).
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // Every state except REQ counts as a fetch stall cycle.
    function automatic logic is_stall_state(input fetch_state_e s);
        return (s != S_REQ);
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of PC-generator, instruction-memory and decode handshakes seen by ifu_fetch.
// master = the fetch stage, slave = its surroundings (PC gen, imem, decode).
interface ifu_fetch_if
    import ifu_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = IFU_DATA_WIDTH,
    parameter int INST_WIDTH = IFU_INST_WIDTH
);
    logic [DATA_WIDTH-1:0] pc;
    logic                  pc_fire;
    logic                  flush;
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic [INST_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  id_valid;
    logic                  id_ready;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [INST_WIDTH-1:0] id_inst;
    logic                  id_fault;

    modport master (
        input  pc, flush, req_ready, rsp_valid, rsp_data, rsp_err, id_ready,
        output pc_fire, req_valid, req_addr, id_valid, id_pc, id_inst, id_fault
    );

    modport slave (
        output pc, flush, req_ready, rsp_valid, rsp_data, rsp_err, id_ready,
        input  pc_fire, req_valid, req_addr, id_valid, id_pc, id_inst, id_fault
    );

endinterface

// File: rtl/ifu_out_buf.sv
// One-entry IF/ID output register backed by a single skid entry; flush empties both.
module ifu_out_buf #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic         skid_valid_r;
    logic [W-1:0] skid_data_r;
    logic         out_free_s;

    assign out_free_s = !out_valid || out_ready;

    // Output register and skid; the skid only fills while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (in_valid) begin
            if (out_free_s) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                skid_valid_r <= 1'b1;
                skid_data_r  <= in_data;
            end
        end else if (out_free_s) begin
            out_valid    <= skid_valid_r;
            skid_valid_r <= 1'b0;
            if (skid_valid_r) begin
                out_data <= skid_data_r;
            end
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one outstanding imem request, wrong-path squash on flush.
// Define IFU_PERF_CNT_EN to add the perf_fetch / perf_stall event counters.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = IFU_DATA_WIDTH,
    parameter int INST_WIDTH = IFU_INST_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] perf_fetch,
    output logic [63:0] perf_stall
`endif
);
    localparam int ENTRY_W = DATA_WIDTH + INST_WIDTH + 1;

    fetch_state_e          state_r;
    logic [DATA_WIDTH-1:0] cur_pc_r;
    logic                  pc_fire_r;

    logic                  req_fire_s;
    logic                  out_free_s;
    logic                  load_s;
    logic [INST_WIDTH-1:0] inst_s;
    logic [ENTRY_W-1:0]    entry_s;
    logic [ENTRY_W-1:0]    out_data_s;

    assign bus.req_valid = (state_r == S_REQ) && !bus.flush;
    assign bus.req_addr  = bus.pc;
    assign bus.pc_fire   = pc_fire_r;

    assign req_fire_s = bus.req_valid && bus.req_ready;
    assign out_free_s = !bus.id_valid || bus.id_ready;
    assign load_s     = (state_r == S_WAIT) && bus.rsp_valid && !bus.flush;

    // A faulting fetch hands decode a NOP so nothing architectural executes.
    always_comb begin
        inst_s = bus.rsp_data;
        if (bus.rsp_err) begin
            inst_s = INST_WIDTH'(INST_NOP);
        end else begin
            inst_s = bus.rsp_data;
        end
    end

    assign entry_s = {cur_pc_r, inst_s, bus.rsp_err};

    // Fetch sequencing; flush takes priority over every other transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_REQ;
            cur_pc_r  <= '0;
            pc_fire_r <= 1'b0;
        end else begin
            pc_fire_r <= 1'b0;
            case (state_r)
                S_REQ: begin
                    if (req_fire_s) begin
                        cur_pc_r  <= bus.pc;
                        pc_fire_r <= 1'b1;
                        state_r   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.flush) begin
                        state_r <= bus.rsp_valid ? S_REQ : S_DROP;
                    end else if (bus.rsp_valid) begin
                        state_r <= out_free_s ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.flush || bus.id_ready) begin
                        state_r <= S_REQ;
                    end
                end
                S_DROP: begin
                    // The outstanding response retires the request even if another flush lands with it.
                    if (bus.rsp_valid) begin
                        state_r <= S_REQ;
                    end
                end
                default: begin
                    state_r <= S_REQ;
                end
            endcase
        end
    end

    ifu_out_buf #(
        .W (ENTRY_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (load_s),
        .in_data   (entry_s),
        .out_ready (bus.id_ready),
        .out_valid (bus.id_valid),
        .out_data  (out_data_s)
    );

    assign {bus.id_pc, bus.id_inst, bus.id_fault} = out_data_s;

`ifdef IFU_PERF_CNT_EN
    // Free-running event counters; they wrap naturally at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch <= 64'd0;
            perf_stall <= 64'd0;
        end else begin
            if (bus.id_valid && bus.id_ready) begin
                perf_fetch <= perf_fetch + 64'd1;
            end
            if (is_stall_state(state_r)) begin
                perf_stall <= perf_stall + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios pinned with literals, then random traffic
// checked every cycle against a transaction-level model (outstanding request + in-order entry queue).
module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    logic clk;
    logic rst;

    ifu_fetch_if #(.DATA_WIDTH(32), .INST_WIDTH(32)) bus ();

`ifdef IFU_PERF_CNT_EN
    logic [63:0] perf_fetch;
    logic [63:0] perf_stall;
`endif

    ifu_fetch #(.DATA_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus knobs
    bit          flush_k    = 1'b0;
    bit          ready_k    = 1'b1;
    bit          rr_k       = 1'b1;
    bit          rand_err_k = 1'b0;
    int          lat_k      = 1;
    logic [31:0] redirect_k = 32'h0;
    logic [31:0] err_at_k   = 32'h0000_0001;

    // PC generator + imem + reference model state
    logic [31:0] pc;
    bit          outst;
    bit          drop;
    int          lat_cnt;
    logic [31:0] out_pc;
    bit          exp_fire;
    longint unsigned exp_fetch;
    longint unsigned exp_stall;
    ent_t        q[$];
    ent_t        dlog[$];
    logic [31:0] reqlog[$];

    // last sampled outputs for directed checks
    logic        last_req_valid;
    logic [31:0] last_req_addr;
    logic        last_id_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t dent(input int i);
        ent_t e;
        e = '{pc: 32'hDEAD_BEEF, inst: 32'hDEAD_BEEF, fault: 1'b0};
        if (i < dlog.size()) e = dlog[i];
        return e;
    endfunction

    function automatic logic [31:0] rq(input int i);
        return (i < reqlog.size()) ? reqlog[i] : 32'hDEAD_BEEF;
    endfunction

    // Called at a negedge; leaves at a negedge with the model reset.
    task automatic do_reset();
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_data  = 32'h0;
        bus.req_ready = 1'b0;
        bus.id_ready  = 1'b0;
        bus.pc        = pc;
        @(negedge clk);
        rst       = 1'b0;
        outst     = 1'b0;
        drop      = 1'b0;
        lat_cnt   = 0;
        exp_fire  = 1'b0;
        exp_fetch = 0;
        exp_stall = 0;
        q.delete();
        dlog.delete();
        reqlog.delete();
    endtask

    // One clock cycle: drive at the negedge, check 1 time unit later, advance the model.
    task automatic cycle();
        bit          f, r, ir, rr, err, exp_rv, dlv, fire_seen;
        logic [31:0] data;
        f    = flush_k;
        ir   = ready_k;
        rr   = rr_k;
        r    = 1'b0;
        err  = 1'b0;
        data = $urandom;
        if (outst) begin
            lat_cnt--;
            if (lat_cnt == 0) r = 1'b1;
        end
        if (r) err = (out_pc == err_at_k) || rand_err_k;
        bus.pc        = pc;
        bus.flush     = f;
        bus.id_ready  = ir;
        bus.req_ready = rr;
        bus.rsp_valid = r;
        bus.rsp_data  = data;
        bus.rsp_err   = err;
        #1;
        exp_rv = !f && !outst && (q.size() <= 1);
        chk("req_valid", bus.req_valid, exp_rv);
        if (exp_rv) chk("req_addr", bus.req_addr, pc);
        chk("pc_fire", bus.pc_fire, exp_fire);
        chk("id_valid", bus.id_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("id_pc", bus.id_pc, q[0].pc);
            chk("id_inst", bus.id_inst, q[0].inst);
            chk("id_fault", bus.id_fault, q[0].fault);
        end
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", perf_fetch, exp_fetch);
        chk("perf_stall", perf_stall, exp_stall);
`endif
        last_req_valid = bus.req_valid;
        last_req_addr  = bus.req_addr;
        last_id_valid  = bus.id_valid;
        fire_seen      = bus.pc_fire;

        dlv = (q.size() > 0) && ir;
        if (dlv) dlog.push_back('{pc: bus.id_pc, inst: bus.id_inst, fault: bus.id_fault});
        if (dlv) exp_fetch++;
        if (outst || q.size() == 2) exp_stall++;

        if (f) begin
            q.delete();
            if (r) begin
                outst = 1'b0;
                drop  = 1'b0;
            end else if (outst) begin
                drop = 1'b1;
            end
        end else begin
            if (dlv) void'(q.pop_front());
            if (r) begin
                if (!drop) q.push_back('{pc: out_pc, inst: err ? 32'h0000_0013 : data, fault: err});
                outst = 1'b0;
                drop  = 1'b0;
            end
        end
        exp_fire = exp_rv && rr;
        if (exp_rv && rr) begin
            outst   = 1'b1;
            lat_cnt = lat_k;
            out_pc  = pc;
            reqlog.push_back(pc);
        end
        if (f) pc = redirect_k;
        else if (fire_seen) pc = pc + 32'd4;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        pc = 32'h8000_0000;
        do_reset();

        // 1: back-to-back fetches, 1-cycle imem, decode always ready
        pc = 32'h8000_0000; lat_k = 1; ready_k = 1'b1; rr_k = 1'b1;
        run(8);
        chk("s1_pc0", dent(0).pc, 32'h8000_0000);
        chk("s1_pc1", dent(1).pc, 32'h8000_0004);
        chk("s1_pc2", dent(2).pc, 32'h8000_0008);

        // 2: decode stalled, second response lands in the skid
        do_reset();
        pc = 32'h8000_0000; ready_k = 1'b0;
        run(7);
        chk("s2_hold_noreq", last_req_valid, 1'b0);
        chk("s2_hold_valid", last_id_valid, 1'b1);
        ready_k = 1'b1;
        run(4);
        chk("s2_pc0", dent(0).pc, 32'h8000_0000);
        chk("s2_pc1", dent(1).pc, 32'h8000_0004);

        // 3: flush while waiting, response 3 cycles later is dropped
        do_reset();
        pc = 32'h8000_0000; lat_k = 4;
        run(1);
        flush_k = 1'b1; redirect_k = 32'h8000_0100; lat_k = 1;
        run(1);
        flush_k = 1'b0;
        run(8);
        chk("s3_req1", rq(1), 32'h8000_0100);
        chk("s3_pc0", dent(0).pc, 32'h8000_0100);

        // 4: flush coincident with the response
        do_reset();
        pc = 32'h8000_0000; lat_k = 1;
        run(1);
        flush_k = 1'b1; redirect_k = 32'h8000_0200;
        run(1);
        flush_k = 1'b0;
        run(1);
        chk("s4_id_valid", last_id_valid, 1'b0);
        chk("s4_req_valid", last_req_valid, 1'b1);
        chk("s4_req_addr", last_req_addr, 32'h8000_0200);
        run(3);
        chk("s4_pc0", dent(0).pc, 32'h8000_0200);

        // 5: access fault
        do_reset();
        pc = 32'h8000_0010; err_at_k = 32'h8000_0010;
        run(3);
        chk("s5_pc", dent(0).pc, 32'h8000_0010);
        chk("s5_inst", dent(0).inst, 32'h0000_0013);
        chk("s5_fault", dent(0).fault, 1'b1);
        err_at_k = 32'h0000_0001;

        // 6: reset while holding a skid entry
        do_reset();
        pc = 32'h8000_0000; ready_k = 1'b0;
        run(5);
        chk("s6_pre_valid", last_id_valid, 1'b1);
        chk("s6_pre_noreq", last_req_valid, 1'b0);
        do_reset();
        run(1);
        chk("s6_id_valid", last_id_valid, 1'b0);
        chk("s6_req_valid", last_req_valid, 1'b1);
`ifdef IFU_PERF_CNT_EN
        chk("s6_perf_fetch", perf_fetch, 64'd0);
        chk("s6_perf_stall", perf_stall, 64'd0);
`endif

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            flush_k    = ($urandom_range(11, 0) == 0);
            ready_k    = ($urandom_range(9, 0) < 6);
            rr_k       = ($urandom_range(9, 0) < 7);
            lat_k      = $urandom_range(3, 1);
            rand_err_k = ($urandom_range(9, 0) == 0);
            redirect_k = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(499, 0) == 0) do_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
